// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read memory port between an instruction-fetch
//   requester and a data (load/store) requester.
//
//   Arbitration
//   - Grants are combinational and at most one is high per cycle.
//   - Data wins by default.
//   - Fetch wins once it has been denied StarveLimit cycles in a row.
//
//   Timing
//   - Read data returns one cycle after the grant.
//   - Stores complete in their grant cycle.
//
//   Ports
//   clk, reset                  clock, synchronous active-high reset
//   if_req/if_addr              fetch request and address
//   if_gnt/if_rvalid/if_rdata   fetch grant and read return
//   d_req/d_we/d_addr/d_wdata/d_func3   data request and payload
//   d_gnt/d_rvalid/d_rdata      data grant and load return
//   mem_addr/mem_we/mem_wdata/mem_func3/mem_rdata   shared memory port
//   stall                       some pending request was not granted this cycle

module mem_port_arbiter #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned StarveLimit = 3
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 if_req,
    input  logic [AddrWidth-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DataWidth-1:0] if_rdata,

    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [AddrWidth-1:0] d_addr,
    input  logic [DataWidth-1:0] d_wdata,
    input  logic [2:0]           d_func3,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [DataWidth-1:0] d_rdata,

    output logic [AddrWidth-1:0] mem_addr,
    output logic                 mem_we,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [2:0]           mem_func3,
    input  logic [DataWidth-1:0] mem_rdata,

    output logic                 stall
);

    localparam int unsigned CntWidth = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
    localparam logic [CntWidth-1:0] StarveMax = CntWidth'(StarveLimit);

    // Owner of the read that returns next cycle.
    localparam logic [1:0] OwnNone = 2'd0;
    localparam logic [1:0] OwnIf   = 2'd1;
    localparam logic [1:0] OwnD    = 2'd2;

    // Fetches are always full-word reads.
    localparam logic [2:0] FetchFunc3 = 3'b010;

    logic [CntWidth-1:0]  starve_q, starve_d;
    logic [1:0]           owner_q, owner_d;
    logic [DataWidth-1:0] if_rdata_q;
    logic [DataWidth-1:0] d_rdata_q;
    logic                 fetch_priority;

    // Grant decision
    always_comb begin
        fetch_priority = if_req && (starve_q == StarveMax);
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            d_gnt  = d_req && !fetch_priority;
            if_gnt = if_req && !d_gnt;
        end
    end

    // Memory port mux: idle port drives all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        if (if_gnt) begin
            mem_addr  = if_addr;
            mem_func3 = FetchFunc3;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
            mem_func3 = d_func3;
        end
    end

    assign stall = !reset && ((if_req && !if_gnt) || (d_req && !d_gnt));

    // Next-state logic
    always_comb begin
        starve_d = '0;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + CntWidth'(1);
        end

        owner_d = OwnNone;
        if (if_gnt) begin
            owner_d = OwnIf;
        end else if (d_gnt && !d_we) begin
            owner_d = OwnD;
        end
    end

    // Read return. Gating with reset ensures a read granted just before
    // reset never signals valid.
    assign if_rvalid = !reset && (owner_q == OwnIf);
    assign d_rvalid  = !reset && (owner_q == OwnD);

    // Returned data passes straight through in the valid cycle and is held
    // in a register otherwise.
    assign if_rdata = reset ? '0 : (if_rvalid ? mem_rdata : if_rdata_q);
    assign d_rdata  = reset ? '0 : (d_rvalid  ? mem_rdata : d_rdata_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            owner_q    <= OwnNone;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
- REQ-001 Parameter DataWidth, default 32, data bus width.
- REQ-002 Parameter AddrWidth, default 32, address bus width.
- REQ-003 Parameter StarveLimit, default 3, maximum consecutive cycles an instruction-fetch request may be denied.
- REQ-004 clk  input  1  single clock; all state changes on its rising edge.
- REQ-005 reset  input  1  synchronous, active-high reset.
- REQ-006 if_req  input  1  instruction-fetch requester asks for a read.
- REQ-007 if_addr  input  AddrWidth  fetch address.
- REQ-008 if_gnt  output  1  fetch request accepted this cycle.
- REQ-009 if_rvalid  output  1  if_rdata valid this cycle.
- REQ-010 if_rdata  output  DataWidth  fetched word.
- REQ-011 d_req  input  1  data requester asks for an access.
- REQ-012 d_we  input  1  1 = store, 0 = load.
- REQ-013 d_addr  input  AddrWidth  data address.
- REQ-014 d_wdata  input  DataWidth  store data.
- REQ-015 d_func3  input  3  access size/sign code, passed to memory.
- REQ-016 d_gnt  output  1  data request accepted this cycle.
- REQ-017 d_rvalid  output  1  d_rdata valid this cycle (loads only).
- REQ-018 d_rdata  output  DataWidth  load result.
- REQ-019 mem_addr  output  AddrWidth  shared memory port address.
- REQ-020 mem_we  output  1  shared memory port write enable.
- REQ-021 mem_wdata  output  DataWidth  shared memory port write data.
- REQ-022 mem_func3  output  3  shared memory port size code.
- REQ-023 mem_rdata  input  DataWidth  memory read data, valid exactly one cycle after the address is presented.
- REQ-024 stall  output  1  high when any pending request is not granted this cycle.

Function
- REQ-025 At most one of if_gnt/d_gnt SHALL be high per cycle; grant is combinational from current requests and state.
- REQ-026 Default priority SHALL be data over fetch.
- REQ-027 Starve counter (saturating, width ceil(log2(StarveLimit+1))) SHALL increment each cycle if_req=1 and if_gnt=0, and clear when if_gnt=1 or if_req=0.
- REQ-028 When starve counter equals StarveLimit and if_req=1, fetch SHALL win over data that cycle.
- REQ-029 Granted requester's addr/func3 (fetch uses func3=3'b010), and for data, we/wdata, SHALL drive mem_* the same cycle; with no grant, mem_we=0, mem_addr, mem_wdata and mem_func3 = 0.
- REQ-030 A 2-bit owner register SHALL record the granted read source (NONE/IF/D); a store records NONE.
- REQ-031 Cycle after a granted read, the owner's rvalid SHALL be 1 and its rdata = mem_rdata; the other rvalid = 0.
- REQ-032 if_rdata/d_rdata SHALL hold their last returned value when rvalid=0.
- REQ-033 Back-to-back grants SHALL be allowed every cycle (read return overlaps next issue); throughput one access per cycle.
- REQ-034 Store SHALL complete in the grant cycle; no response strobe.
- REQ-035 stall = (if_req & ~if_gnt) | (d_req & ~d_gnt).
- REQ-036 Requesters SHALL hold req and payload stable until granted; arbiter need not latch them.

Reset
- REQ-037 While reset=1: grants, rvalids, mem_we = 0; owner=NONE; starve counter=0; rdata registers=0; stall=0 regardless of requests.
- REQ-038 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset.
- REQ-039 First grant possible in the first cycle with reset=0.

Verification
- REQ-040 if_req=1, if_addr=0x10, d_req=0; mem_rdata=0xA5A5A5A5 next cycle -> if_gnt=1, mem_addr=0x10, mem_func3=3'b010; next cycle if_rvalid=1, if_rdata=0xA5A5A5A5.
- REQ-041 if_req and d_req both held high, d_we=0, d_func3=3'b010, StarveLimit=3 -> d_gnt cycles 1-3, if_gnt cycle 4, d_gnt cycle 5; stall high every cycle.
- REQ-042 Store d_we=1, d_addr=0x40, d_wdata=0x12345678, d_func3=3'b010 -> mem_we=1 same cycle, mem_addr=0x40, mem_wdata=0x12345678; next cycle d_rvalid=0.
- REQ-043 Alternating d load 0x20 then fetch 0x24 in consecutive cycles -> d_rvalid in cycle 2, if_rvalid in cycle 3, never both high.
- REQ-044 Fetch granted, reset=1 next cycle -> if_rvalid=0, all outputs at reset values, starve counter 0.
- REQ-045 No requests for 5 cycles -> stall=0, mem_we=0, rvalids 0, rdata unchanged.
